// File: rtl/mux_pipe_n_pkg.sv
// Shared definitions for the registered N:1 selector.
//   - state_e       : skid-buffer occupancy (EMPTY / ONE / TWO)
//   - DEFAULT_WIDTH : default data width, sized for a register address
//   - clog2         : constant helper used to validate the select width
package mux_pipe_n_pkg;

  localparam int unsigned DEFAULT_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Smallest n with 2**n >= value.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_pipe_n_sel.sv
// Purely combinational NUM_IN:1 selector with an all-zeros default.
// Kept standalone so the register-file write path can reuse it.
// Ports:
//   i_data : flattened channels, channel k at [k*WIDTH +: WIDTH]
//   i_sel  : channel select
//   o_data : selected channel, or zero when i_sel >= NUM_IN
module mux_sel_comb
  import mux_pipe_n_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned SEL_W  = 2
) (
  input  logic [NUM_IN*WIDTH-1:0] i_data,
  input  logic [SEL_W-1:0]        i_sel,
  output logic [WIDTH-1:0]        o_data
);

  always_comb begin
    o_data = '0;
    for (int k = 0; k < int'(NUM_IN); k++) begin
      if (i_sel == SEL_W'(k)) o_data = i_data[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_pipe_n.sv
// Registered N:1 selector with valid/ready on both sides. A two-entry skid
// buffer (main + skid register) gives one-cycle latency, full throughput and a
// registered in_ready. Selection is done at capture time.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   in_data/sel         : flattened channels and select, taken on in_valid & in_ready
//   in_valid/in_ready   : upstream handshake (in_ready registered)
//   out_data/out_valid  : registered selected word and its qualifier
//   out_ready           : downstream accept
//   sel_err             : sticky out-of-range select flag
// Optional feature macro: MUX_SEL_CHECK_EN (sticky sel_err). When undefined
// sel_err is tied low and no extra flop exists.
module mux_pipe_n
  import mux_pipe_n_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  if (NUM_IN < 2 || SEL_W < clog2(NUM_IN)) begin : g_bad_params
    $error("mux_pipe_n: need NUM_IN >= 2 and 2**SEL_W >= NUM_IN");
  end

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_main, w_main_d;
  logic [WIDTH-1:0] r_skid, w_skid_d;
  logic             r_in_ready;
  logic [WIDTH-1:0] w_value;
  logic             w_xfer_in;
  logic             w_xfer_out;

  mux_sel_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_sel (
    .i_data (in_data),
    .i_sel  (sel),
    .o_data (w_value)
  );

  assign out_valid  = (r_state != ST_EMPTY);
  assign out_data   = r_main;
  assign in_ready   = r_in_ready;
  assign w_xfer_in  = in_valid & r_in_ready;
  assign w_xfer_out = out_valid & out_ready;

  always_comb begin
    w_state_d = r_state;
    w_main_d  = r_main;
    w_skid_d  = r_skid;
    unique case (r_state)
      ST_EMPTY: begin
        if (w_xfer_in) begin
          w_main_d  = w_value;
          w_state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_xfer_in && w_xfer_out) begin
          w_main_d = w_value;
        end else if (w_xfer_in) begin
          // Main is still held downstream; park the new word behind it.
          w_skid_d  = w_value;
          w_state_d = ST_TWO;
        end else if (w_xfer_out) begin
          w_state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only a drain can happen.
        if (w_xfer_out) begin
          w_main_d  = r_skid;
          w_state_d = ST_ONE;
        end
      end
      default: w_state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_main     <= '0;
      r_skid     <= '0;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_main     <= w_main_d;
      r_skid     <= w_skid_d;
      // Look-ahead on the next state keeps in_ready a plain flop output.
      r_in_ready <= (w_state_d != ST_TWO);
    end
  end

`ifdef MUX_SEL_CHECK_EN
  logic w_sel_oob;
  logic r_sel_err;

  always_comb begin
    w_sel_oob = 1'b1;
    for (int k = 0; k < int'(NUM_IN); k++) begin
      if (sel == SEL_W'(k)) w_sel_oob = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel_err <= 1'b0;
    end else if (w_xfer_in && w_sel_oob) begin
      r_sel_err <= 1'b1;
    end
  end

  assign sel_err = r_sel_err;
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_pipe_n.sv
module tb_mux_pipe_n;

  logic        clk;
  logic        reset;
  logic [14:0] in_data;
  logic [1:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        sel_err;

  int total = 0;
  int bad   = 0;
  int out_cnt = 0;
  logic exp_err = 1'b0;
  logic [4:0] sb_q[$];

  typedef struct {
    logic [4:0] ch0;
    logic [4:0] ch1;
    logic [4:0] ch2;
    logic [1:0] s;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[8];

  mux_pipe_n #(
    .WIDTH  (5),
    .NUM_IN (3),
    .SEL_W  (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [4:0] model(input logic [14:0] d, input logic [1:0] s);
    case (s)
      2'd0:    return d[4:0];
      2'd1:    return d[9:5];
      2'd2:    return d[14:10];
      default: return 5'd0;
    endcase
  endfunction

  // Scoreboard: inputs are stable from posedge+1 through the next posedge,
  // so sampling at the negedge sees exactly the handshakes of the coming edge.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        out_cnt++;
        if (sb_q.size() == 0) begin
          check("sb_unexpected_output", 32'(out_data), 32'hFFFF);
        end else begin
          check("sb_order", 32'(out_data), 32'(sb_q.pop_front()));
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model(in_data, sel));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{5'd3,  5'd17, 5'd31, 2'd1, 5'd17};
    vecs[1] = '{5'd3,  5'd17, 5'd31, 2'd0, 5'd3};
    vecs[2] = '{5'd3,  5'd17, 5'd31, 2'd2, 5'd31};
    vecs[3] = '{5'd30, 5'd1,  5'd8,  2'd2, 5'd8};
    vecs[4] = '{5'd30, 5'd1,  5'd8,  2'd3, 5'd0};
    vecs[5] = '{5'd6,  5'd25, 5'd12, 2'd0, 5'd6};
    vecs[6] = '{5'd6,  5'd25, 5'd12, 2'd1, 5'd25};
    vecs[7] = '{5'd31, 5'd31, 5'd31, 2'd3, 5'd0};

    reset = 1'b1; in_data = '0; sel = '0; in_valid = 1'b0; out_ready = 1'b0;

    // Reset release
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_sel_err", 32'(sel_err), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    reset = 1'b0;
    #1;
    check("in_ready_before_edge", 32'(in_ready), 0);
    tick();
    check("in_ready_after_edge", 32'(in_ready), 1);

    // Single transfers from the vector table
    for (int i = 0; i < 8; i++) begin
      in_data = {vecs[i].ch2, vecs[i].ch1, vecs[i].ch0};
      sel = vecs[i].s;
      in_valid = 1'b1;
      out_ready = 1'b1;
`ifdef MUX_SEL_CHECK_EN
      if (vecs[i].s == 2'd3) exp_err = 1'b1;
`endif
      tick();
      in_valid = 1'b0;
      sel = 2'd3;  // must be ignored without a transfer
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 1);
      check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].exp));
      check($sformatf("vec%0d_sel_err", i), 32'(sel_err), 32'(exp_err));
      tick();
      check($sformatf("vec%0d_drained", i), 32'(out_valid), 0);
    end
    check("sel_err_idle_sel", 32'(sel_err), 32'(exp_err));

    // Streaming: 30 words, no bubbles, in_ready never drops
    begin
      int start_cnt;
      start_cnt = out_cnt;
      out_ready = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 30; i++) begin
        sel = 2'(i % 3);
        in_data = 15'($urandom());
        tick();
        check($sformatf("stream%0d_in_ready", i), 32'(in_ready), 1);
        check($sformatf("stream%0d_out_valid", i), 32'(out_valid), 1);
      end
      in_valid = 1'b0;
      tick();
      tick();
      check("stream_count", 32'(out_cnt - start_cnt), 30);
    end

    // Backpressure: three offered, two accepted, output held stable
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = {5'd9, 5'd20, 5'd4};
    sel = 2'd0;
    tick();
    check("bp_first_in_ready", 32'(in_ready), 1);
    sel = 2'd1;
    tick();
    check("bp_full_in_ready", 32'(in_ready), 0);
    sel = 2'd2;
    tick();
    check("bp_refused_in_ready", 32'(in_ready), 0);
    check("bp_hold_data", 32'(out_data), 4);
    tick();
    check("bp_stable_data", 32'(out_data), 4);
    check("bp_stable_valid", 32'(out_valid), 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_pre_drain", 32'(in_ready), 0);
    tick();
    check("bp_in_ready_after_drain", 32'(in_ready), 1);
    check("bp_second_word", 32'(out_data), 20);
    tick();
    check("bp_empty", 32'(out_valid), 0);

    // Mid-operation reset with both registers full
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = {5'd13, 5'd14, 5'd15};
    sel = 2'd0;
    tick();
    sel = 2'd1;
    tick();
    in_valid = 1'b0;
    check("mid_full", 32'(in_ready), 0);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_in_ready", 32'(in_ready), 0);
    tick();
    tick();
    reset = 1'b0;
    exp_err = 1'b0;
    check("mid_rst_sel_err", 32'(sel_err), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("post_rst_no_stale%0d", i), 32'(out_valid), 0);
    end
    in_data = {5'd7, 5'd5, 5'd11};
    sel = 2'd2;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post_rst_fresh", 32'(out_data), 7);
    check("post_rst_fresh_valid", 32'(out_valid), 1);
    tick();
    tick();
    check("sb_empty", 32'(sb_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
